// File: rtl/clkdiv_meas.sv
// Measures period (and optionally high time) of an asynchronous clock-like input in clk_i cycles.
// Optional feature: define CLKDIV_MEAS_DUTY_EN to add the high_o output and duty-aware lock.
module clkdiv_meas #(
    parameter int CNT_W       = 8,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             clk_s,
    output logic [CNT_W-1:0] period_o,
`ifdef CLKDIV_MEAS_DUTY_EN
    output logic [CNT_W-1:0] high_o,
`endif
    output logic             valid_o,
    output logic             lock_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q;
    logic                   rise, fall;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   lock_q, lock_d;
    logic                   timeout_q, timeout_d;
    logic [3:0]             match_q, match_d;
    logic                   have_prev_q, have_prev_d;
    logic                   same_meas;

`ifdef CLKDIV_MEAS_DUTY_EN
    logic [CNT_W-1:0]       high_q, high_d;
    logic [CNT_W-1:0]       high_cap_q, high_cap_d;
`endif

    assign sync_d[0] = clk_s;
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        assign sync_d[gi] = sync_q[gi-1];
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        lock_d      = lock_q;
        timeout_d   = timeout_q;
        match_d     = match_q;
        have_prev_d = have_prev_q;
        same_meas   = have_prev_q && (cnt_q == period_q);
`ifdef CLKDIV_MEAS_DUTY_EN
        high_d      = high_q;
        high_cap_d  = high_cap_q;
        same_meas   = same_meas && (high_cap_q == high_q);
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d   = ST_MEAS;
                    cnt_d     = CNT_ONE;
                    timeout_d = 1'b0;
                end
            end
            ST_MEAS: begin
                // A rise on the terminal count still counts as a valid period.
                if (rise) begin
                    period_d    = cnt_q;
                    valid_d     = 1'b1;
                    cnt_d       = CNT_ONE;
                    have_prev_d = 1'b1;
`ifdef CLKDIV_MEAS_DUTY_EN
                    high_d      = high_cap_q;
`endif
                    if (same_meas) begin
                        match_d = (match_q >= LOCK_TGT) ? LOCK_TGT : match_q + 4'd1;
                    end else begin
                        match_d = '0;
                    end
                    lock_d = (match_d == LOCK_TGT);
                end else if (cnt_q == CNT_MAX) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    timeout_d   = 1'b1;
                    lock_d      = 1'b0;
                    match_d     = '0;
                    have_prev_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
`ifdef CLKDIV_MEAS_DUTY_EN
                    if (fall) begin
                        high_cap_d = cnt_q;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            lock_q      <= 1'b0;
            timeout_q   <= 1'b0;
            match_q     <= '0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            lock_q      <= lock_d;
            timeout_q   <= timeout_d;
            match_q     <= match_d;
            have_prev_q <= have_prev_d;
        end
    end

`ifdef CLKDIV_MEAS_DUTY_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            high_q     <= '0;
            high_cap_q <= '0;
        end else begin
            high_q     <= high_d;
            high_cap_q <= high_cap_d;
        end
    end

    assign high_o = high_q;
`else
    // Fall edges only matter when the high time is measured.
    logic unused_fall;
    assign unused_fall = fall;
`endif

    assign period_o  = period_q;
    assign valid_o   = valid_q;
    assign lock_o    = lock_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_clkdiv_meas.sv
// Self-checking bench for clkdiv_meas: timestamp-based reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_clkdiv_meas;

    localparam int CNT_W = 4;
    localparam int LOCK_CNT = 4;
    localparam int SYNC = 2;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    logic clk_s = 1'b0;
    logic [CNT_W-1:0] period_o;
    logic valid_o, lock_o, timeout_o;
`ifdef CLKDIV_MEAS_DUTY_EN
    logic [CNT_W-1:0] high_o;
`endif

    clkdiv_meas #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .SYNC_STAGES(SYNC)) dut (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .clk_s    (clk_s),
        .period_o (period_o),
`ifdef CLKDIV_MEAS_DUTY_EN
        .high_o   (high_o),
`endif
        .valid_o  (valid_o),
        .lock_o   (lock_o),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_chk = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: events are timestamped by clk_i cycle; periods are timestamp differences.
    bit dh [0:32767];
    int cyc = 0, m0 = 0;
    int armed, have_prev, last_rise, last_fall, match;
    int exp_period, exp_high, exp_valid, exp_lock, exp_timeout;

    function automatic int d_at(input int k);
        if (k < m0) return 0;
        return int'(dh[k & 32767]);
    endfunction

    task automatic model_reset();
        armed = 0; have_prev = 0; last_rise = 0; last_fall = 0; match = 0;
        exp_period = 0; exp_high = 0; exp_valid = 0; exp_lock = 0; exp_timeout = 0;
    endtask

    task automatic model_step(input int m);
        int e, f, p, h, same;
        // The synchronized level seen at cycle m is the input sampled SYNC cycles earlier.
        e = d_at(m - SYNC) & (1 - d_at(m - SYNC - 1));
        f = (1 - d_at(m - SYNC)) & d_at(m - SYNC - 1);
        exp_valid = 0;
        if (!armed) begin
            if (e) begin armed = 1; last_rise = m; exp_timeout = 0; end
        end else if (e) begin
            p = m - last_rise;
            h = last_fall - last_rise;
            same = have_prev && (p == exp_period);
`ifdef CLKDIV_MEAS_DUTY_EN
            same = same && (h == exp_high);
`endif
            match = same ? ((match + 1 > LOCK_CNT) ? LOCK_CNT : match + 1) : 0;
            exp_period = p; exp_high = h; exp_valid = 1;
            exp_lock = (match == LOCK_CNT) ? 1 : 0;
            have_prev = 1; last_rise = m;
        end else if (m - last_rise == MAXC) begin
            exp_timeout = 1; exp_lock = 0; match = 0; have_prev = 0; armed = 0;
        end else if (f) begin
            last_fall = m;
        end
    endtask

    // Observations used by the directed literal checks.
    int valid_cnt, lock_rise_idx, last_per, last_high, last_valid_cyc;
    int prev_lock, prev_timeout, to_diff, lock_at_to, valid_at_clear;
    int watch6, idx6, first6_lock, lock_after6;

    task automatic mark();
        valid_cnt = 0; lock_rise_idx = 0; to_diff = -1; lock_at_to = -1;
        valid_at_clear = -1; watch6 = 0; idx6 = 0; first6_lock = -1; lock_after6 = 0;
    endtask

    initial begin
        model_reset();
        mark();
        prev_lock = 0; prev_timeout = 0; last_valid_cyc = 0; last_per = 0; last_high = 0;
        forever begin
            @(posedge clk_i);
            cyc++;
            if (!rst_n) begin
                model_reset();
                m0 = cyc + 1;
            end else begin
                dh[cyc & 32767] = clk_s;
                model_step(cyc);
            end
            #1;
            check("period_o", int'(period_o), exp_period);
            check("valid_o", int'(valid_o), exp_valid);
            check("lock_o", int'(lock_o), exp_lock);
            check("timeout_o", int'(timeout_o), exp_timeout);
`ifdef CLKDIV_MEAS_DUTY_EN
            check("high_o", int'(high_o), exp_high);
            if (valid_o) last_high = int'(high_o);
`endif
            if (valid_o) begin
                valid_cnt++;
                last_per = int'(period_o);
                last_valid_cyc = cyc;
                if (lock_o && !prev_lock && lock_rise_idx == 0) lock_rise_idx = valid_cnt;
                if (idx6 > 0) begin
                    idx6++;
                    if (lock_o && lock_after6 == 0) lock_after6 = idx6;
                end else if (watch6 && period_o == CNT_W'(6)) begin
                    idx6 = 1;
                    first6_lock = int'(lock_o);
                end
            end
            if (timeout_o && !prev_timeout && to_diff < 0) begin
                to_diff = cyc - last_valid_cyc;
                lock_at_to = int'(lock_o);
            end
            if (!timeout_o && prev_timeout && valid_at_clear < 0) valid_at_clear = int'(valid_o);
            prev_lock = int'(lock_o);
            prev_timeout = int'(timeout_o);
        end
    end

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge clk_i);
            clk_s = v;
        end
    endtask

    task automatic run_div(input int p, input int h, input int n);
        repeat (n) begin
            drive(1'b1, h);
            drive(1'b0, p - h);
        end
    endtask

    int rp, rh, rn;

    initial begin
        repeat (4) @(negedge clk_i);
        rst_n = 1'b1;

        // Input tied low: nothing ever happens.
        drive(1'b0, 1000);
        check("idle_period", int'(period_o), 0);
        check("idle_valid_cnt", valid_cnt, 0);
        check("idle_lock", int'(lock_o), 0);
        check("idle_timeout", int'(timeout_o), 0);

        // DIV=2: lock on the 5th valid.
        mark();
        run_div(2, 1, 10);
        drive(1'b0, 3);
        check("div2_lock_idx", lock_rise_idx, 5);
        check("div2_period", last_per, 2);
        check("div2_valid_cnt", valid_cnt, 9);
        check("div2_timeout", int'(timeout_o), 0);

        run_div(3, 1, 6);
        drive(1'b0, 3);
        check("div3_period", last_per, 3);
`ifdef CLKDIV_MEAS_DUTY_EN
        check("div3_high", last_high, 1);
`endif

        run_div(4, 2, 8);
        check("div4_period", int'(period_o), 4);
        check("div4_lock", int'(lock_o), 1);
`ifdef CLKDIV_MEAS_DUTY_EN
        check("div4_high", int'(high_o), 2);
`endif

        // Switch to period 6, then stop toggling.
        mark();
        watch6 = 1;
        run_div(6, 3, 7);
        drive(1'b0, 25);
        check("p6_first_lock", first6_lock, 0);
        check("p6_relock_idx", lock_after6, 5);
        check("timeout_delay", to_diff, 15);
        check("timeout_lock", lock_at_to, 0);
        check("timeout_held", int'(timeout_o), 1);

        mark();
        run_div(5, 2, 3);
        drive(1'b0, 4);
        check("clear_valid", valid_at_clear, 0);
        check("after_to_valid_cnt", valid_cnt, 2);
        check("after_to_period", last_per, 5);
        check("after_to_timeout", int'(timeout_o), 0);

        // Rise exactly on the terminal count.
        run_div(15, 3, 4);
        check("terminal_period", int'(period_o), 15);
        check("terminal_timeout", int'(timeout_o), 0);
        drive(1'b0, 20);

        for (int s = 0; s < 40; s++) begin
            rp = $urandom_range(2, 16);
            rh = $urandom_range(1, rp - 1);
            rn = $urandom_range(1, 6);
            run_div(rp, rh, rn);
            if ($urandom_range(0, 4) == 0) drive(1'b0, $urandom_range(8, 20));
        end

        // Lock, then reset mid-period.
        drive(1'b0, 20);
        run_div(3, 1, 8);
        @(posedge clk_i);
        #2;
        check("pre_reset_lock", int'(lock_o), 1);
        rst_n = 1'b0;
        #1;
        check("async_period", int'(period_o), 0);
        check("async_valid", int'(valid_o), 0);
        check("async_lock", int'(lock_o), 0);
        check("async_timeout", int'(timeout_o), 0);
        mark();
        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        run_div(3, 1, 1);
        @(posedge clk_i);
        #2;
        check("rst_first_rise_valid_cnt", valid_cnt, 0);
        run_div(3, 1, 8);
        @(posedge clk_i);
        #2;
        check("rst_valid_cnt", valid_cnt, 8);
        check("rst_lock_idx", lock_rise_idx, 5);
        check("rst_period", int'(period_o), 3);

        drive(1'b0, 5);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
